// File: rtl/prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package prefetch_buffer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } pf_state_e;

  localparam int unsigned INSTR_WIDTH   = 32;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] addr;
    logic [INSTR_WIDTH-1:0] instr;
  } fifo_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/prefetch_buffer_fifo.sv
// DEPTH-entry {addr, instr} FIFO; flush beats push and pop, no write-to-read bypass.
module fetch_fifo
  import prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  fifo_entry_t      push_data_i,
  input  logic             pop_i,
  output fifo_entry_t      head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '{addr: 32'h0000_0000, instr: 32'h0000_0000};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s && !flush_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/prefetch_buffer.sv
// Sequential instruction prefetcher: request FSM, fetch/response PCs, outstanding
// and discard accounting, feeding a small FIFO towards the IF stage.
module prefetch_buffer
  import prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] boot_addr_i,
  input  logic        fetch_enable_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        busy_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i
);

  localparam int unsigned SUM_W = CNT_W + 2;

  pf_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [31:0]      redir_addr_q, redir_addr_d;
  logic             redir_q, redir_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] disc_q, disc_d;

  logic             grant_s;
  logic             live_grant_s;
  logic             rv_owned_s;
  logic             add_one_s;
  logic [SUM_W-1:0] inflight_s;
  logic [SUM_W-1:0] disc_sum_s;
  logic             credit_idle_s;
  logic             credit_stay_s;

  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;
  fifo_entry_t      fifo_head_s;
  fifo_entry_t      fifo_wdata_s;

  // A grant while redir_q is set belongs to a request already counted as a discard.
  assign grant_s      = (state_q == REQ) && instr_gnt_i;
  assign live_grant_s = grant_s && !redir_q && !branch_i;
  assign rv_owned_s   = instr_rvalid_i && ((disc_q != {CNT_W{1'b0}}) || (out_q != {CNT_W{1'b0}}));
  assign add_one_s    = (state_q == REQ) && !redir_q;

  // Discards are included in the credit so every counter stays bounded by DEPTH.
  assign inflight_s    = {2'b00, fifo_count_s} + {2'b00, out_q} + {2'b00, disc_q};
  assign credit_idle_s = inflight_s < SUM_W'(DEPTH);
  assign credit_stay_s = (inflight_s + SUM_W'(1)) < SUM_W'(DEPTH);
  assign disc_sum_s    = {2'b00, disc_q} + {2'b00, out_q} + SUM_W'(add_one_s) - SUM_W'(rv_owned_s);

  assign fifo_push_s  = instr_rvalid_i && !branch_i && (disc_q == {CNT_W{1'b0}}) &&
                        (out_q != {CNT_W{1'b0}}) && !fifo_full_s;
  assign fifo_pop_s   = fetch_valid_o && fetch_ready_i;
  assign fifo_wdata_s = '{addr: rsp_pc_q, instr: instr_rdata_i};

  assign instr_req_o   = (state_q == REQ);
  assign instr_addr_o  = pc_q;
  assign fetch_valid_o = !fifo_empty_s;
  assign fetch_rdata_o = fifo_head_s.instr;
  assign fetch_addr_o  = fifo_head_s.addr;
  assign busy_o        = (out_q != {CNT_W{1'b0}}) || (disc_q != {CNT_W{1'b0}});

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rsp_pc_d     = rsp_pc_q;
    redir_d      = redir_q;
    redir_addr_d = redir_addr_q;
    out_d        = out_q;
    disc_d       = disc_q;

    case (state_q)
      IDLE: begin
        if (fetch_enable_i && credit_idle_s) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (instr_gnt_i) begin
          state_d = (fetch_enable_i && credit_stay_s) ? REQ : IDLE;
        end else begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (branch_i) begin
      disc_d   = disc_sum_s[CNT_W-1:0];
      out_d    = {CNT_W{1'b0}};
      rsp_pc_d = align_pc(branch_addr_i);
      // An ungranted request must keep its address; the target waits in redir_addr_q.
      if ((state_q == REQ) && !instr_gnt_i) begin
        redir_d      = 1'b1;
        redir_addr_d = align_pc(branch_addr_i);
      end else begin
        redir_d = 1'b0;
        pc_d    = align_pc(branch_addr_i);
      end
    end else begin
      if (grant_s && redir_q) begin
        pc_d    = redir_addr_q;
        redir_d = 1'b0;
      end else if (grant_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      if (instr_rvalid_i && (disc_q != {CNT_W{1'b0}})) begin
        disc_d = disc_q - CNT_W'(1);
      end else begin
        disc_d = disc_q;
      end
      if (fifo_push_s) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end else begin
        rsp_pc_d = rsp_pc_q;
      end
      case ({live_grant_s, fifo_push_s})
        2'b10:   out_d = out_q + CNT_W'(1);
        2'b01:   out_d = out_q - CNT_W'(1);
        default: out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= align_pc(boot_addr_i);
      rsp_pc_q     <= align_pc(boot_addr_i);
      redir_q      <= 1'b0;
      redir_addr_q <= 32'h0000_0000;
      out_q        <= {CNT_W{1'b0}};
      disc_q       <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rsp_pc_q     <= rsp_pc_d;
      redir_q      <= redir_d;
      redir_addr_q <= redir_addr_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (branch_i),
    .push_i      (fifo_push_s),
    .push_data_i (fifo_wdata_s),
    .pop_i       (fifo_pop_s),
    .head_o      (fifo_head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer; memory returns ~addr one cycle after each grant.
module tb_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] boot_addr_i = 32'h0000_0080;
  logic        fetch_enable_i = 1'b1;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = 32'h0000_0000;
  logic        fetch_valid_o;
  logic        fetch_ready_i = 1'b1;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        busy_o;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_rdata_i = 32'h0000_0000;

  int          errors = 0;
  int          checks = 0;
  int          gnt_cnt = 0;
  logic        gnt_en = 1'b1;
  logic        rsp_en = 1'b1;
  logic [31:0] pend_q [$];

  always #5 clk = ~clk;

  prefetch_buffer dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .boot_addr_i    (boot_addr_i),
    .fetch_enable_i (fetch_enable_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_addr_o   (fetch_addr_o),
    .busy_o         (busy_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rdata_i  (instr_rdata_i)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then act as memory for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rsp_en && pend_q.size() != 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = ~pend_q.pop_front();
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0000_0000;
    end
    instr_gnt_i = gnt_en;
    if (instr_req_o && gnt_en) begin
      pend_q.push_back(instr_addr_o);
      gnt_cnt++;
    end
  endtask

  task automatic do_reset(input logic [31:0] boot);
    rst_i       = 1'b1;
    boot_addr_i = boot;
    repeat (4) tick();
    rst_i = 1'b0;
  endtask

  initial begin
    // Reset state and basic streaming
    do_reset(32'h0000_0080);
    chk1("rst_req", instr_req_o, 1'b0);
    chk1("rst_valid", fetch_valid_o, 1'b0);
    chk32("rst_rdata", fetch_rdata_o, 32'h0000_0000);
    chk32("rst_faddr", fetch_addr_o, 32'h0000_0000);
    chk1("rst_busy", busy_o, 1'b0);
    tick();
    chk1("s1_req", instr_req_o, 1'b1);
    chk32("s1_addr", instr_addr_o, 32'h0000_0080);
    tick();
    chk32("s2_addr", instr_addr_o, 32'h0000_0084);
    chk1("s2_valid", fetch_valid_o, 1'b0);
    tick();
    chk1("s3_valid", fetch_valid_o, 1'b1);
    chk32("s3_faddr", fetch_addr_o, 32'h0000_0080);
    chk32("s3_rdata", fetch_rdata_o, ~32'h0000_0080);
    chk32("s3_addr", instr_addr_o, 32'h0000_0088);
    tick();
    chk32("s4_faddr", fetch_addr_o, 32'h0000_0084);
    tick();
    chk32("s5_faddr", fetch_addr_o, 32'h0000_0088);

    // Back-pressure: credit limit of 4
    fetch_ready_i = 1'b0;
    do_reset(32'h0000_0080);
    gnt_cnt = 0;
    repeat (12) tick();
    chk32("bp_grants", gnt_cnt, 32'd4);
    chk1("bp_req", instr_req_o, 1'b0);
    chk32("bp_head", fetch_addr_o, 32'h0000_0080);
    fetch_ready_i = 1'b1;
    tick();
    chk32("bp_d1", fetch_addr_o, 32'h0000_0084);
    tick();
    chk32("bp_d2", fetch_addr_o, 32'h0000_0088);
    chk1("bp_resume_req", instr_req_o, 1'b1);
    chk32("bp_resume_addr", instr_addr_o, 32'h0000_0090);
    tick();
    chk32("bp_d3", fetch_addr_o, 32'h0000_008C);
    tick();
    chk32("bp_d4", fetch_addr_o, 32'h0000_0090);

    // Grant withheld for three cycles
    gnt_en = 1'b0;
    do_reset(32'h0000_0080);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("hold_req", instr_req_o, 1'b1);
      chk32("hold_addr", instr_addr_o, 32'h0000_0080);
    end
    gnt_en = 1'b1;
    tick();
    chk32("hold_gnt_addr", instr_addr_o, 32'h0000_0080);
    tick();
    chk32("hold_next_addr", instr_addr_o, 32'h0000_0084);

    // Branch with two outstanding plus one pending ungranted request
    rsp_en = 1'b0;
    do_reset(32'h0000_0080);
    tick();
    tick();
    gnt_en = 1'b0;
    tick();
    chk1("br_busy_pre", busy_o, 1'b1);
    branch_i       = 1'b1;
    branch_addr_i  = 32'h0000_0203;
    fetch_enable_i = 1'b0;
    tick();
    branch_i = 1'b0;
    chk1("br_req_held", instr_req_o, 1'b1);
    chk32("br_old_addr", instr_addr_o, 32'h0000_0088);
    chk1("br_valid4", fetch_valid_o, 1'b0);
    gnt_en = 1'b1;
    rsp_en = 1'b1;
    tick();
    chk32("br_old_addr5", instr_addr_o, 32'h0000_0088);
    chk1("br_valid5", fetch_valid_o, 1'b0);
    tick();
    chk1("br_req6", instr_req_o, 1'b0);
    chk1("br_valid6", fetch_valid_o, 1'b0);
    chk1("br_busy6", busy_o, 1'b1);
    tick();
    chk1("br_valid7", fetch_valid_o, 1'b0);
    chk1("br_busy7", busy_o, 1'b1);
    tick();
    chk1("br_valid8", fetch_valid_o, 1'b0);
    chk1("br_busy8", busy_o, 1'b0);
    fetch_enable_i = 1'b1;
    tick();
    chk1("br_tgt_req", instr_req_o, 1'b1);
    chk32("br_tgt_addr", instr_addr_o, 32'h0000_0200);
    tick();
    chk1("br_valid10", fetch_valid_o, 1'b0);
    tick();
    chk1("br_valid11", fetch_valid_o, 1'b1);
    chk32("br_faddr", fetch_addr_o, 32'h0000_0200);
    chk32("br_rdata", fetch_rdata_o, ~32'h0000_0200);

    // Branch coinciding with rvalid and pop on a nonempty FIFO
    fetch_ready_i = 1'b0;
    do_reset(32'h0000_0080);
    tick();
    tick();
    tick();
    chk1("bx_valid_pre", fetch_valid_o, 1'b1);
    chk1("bx_rvalid_pre", instr_rvalid_i, 1'b1);
    fetch_ready_i = 1'b1;
    branch_i      = 1'b1;
    branch_addr_i = 32'h0000_0300;
    tick();
    branch_i = 1'b0;
    chk1("bx_flushed", fetch_valid_o, 1'b0);
    chk32("bx_tgt_addr", instr_addr_o, 32'h0000_0300);
    tick();
    chk1("bx_valid5", fetch_valid_o, 1'b0);
    tick();
    chk1("bx_valid6", fetch_valid_o, 1'b1);
    chk32("bx_faddr", fetch_addr_o, 32'h0000_0300);
    chk32("bx_rdata", fetch_rdata_o, ~32'h0000_0300);

    // Address wrap, then reset mid-fetch with a late rvalid
    do_reset(32'hFFFF_FFFA);
    tick();
    chk32("wr_a1", instr_addr_o, 32'hFFFF_FFF8);
    tick();
    chk32("wr_a2", instr_addr_o, 32'hFFFF_FFFC);
    tick();
    chk32("wr_a3", instr_addr_o, 32'h0000_0000);
    chk32("wr_f1", fetch_addr_o, 32'hFFFF_FFF8);
    tick();
    chk32("wr_f2", fetch_addr_o, 32'hFFFF_FFFC);
    tick();
    chk32("wr_f3", fetch_addr_o, 32'h0000_0000);
    chk32("wr_r3", fetch_rdata_o, ~32'h0000_0000);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk1("mr_valid", fetch_valid_o, 1'b0);
    chk1("mr_busy", busy_o, 1'b0);
    chk1("mr_req", instr_req_o, 1'b0);
    chk32("mr_rdata", fetch_rdata_o, 32'h0000_0000);
    chk1("mr_late_rvalid", instr_rvalid_i, 1'b1);
    tick();
    chk1("mr_valid7", fetch_valid_o, 1'b0);
    chk1("mr_busy7", busy_o, 1'b0);
    chk32("mr_addr7", instr_addr_o, 32'hFFFF_FFF8);
    tick();
    chk1("mr_valid8", fetch_valid_o, 1'b0);
    tick();
    chk1("mr_valid9", fetch_valid_o, 1'b1);
    chk32("mr_faddr9", fetch_addr_o, 32'hFFFF_FFF8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
